aes128_key_sched_ctrl: RTL and testbench
========================================

Name: aes128_key_sched_ctrl

Overview:
Sequencer and round-key store for the AES-128 key expansion datapath (aes128_key_expansion).
- On a start request it drives the expansion's round_num and rkey_en through rounds 0..9.
- It captures the cipher key and all 10 round keys into an 11-entry store.
- It then serves any round key by index, in any order, so both the encrypt and decrypt cipher cores can share one expansion instance.

Parameters:
- NUM_RKEYS, 11, number of stored keys (cipher key + 10 round keys); only 11 is legal.
- ZEROIZE_ON_CLR, 1, when 1 key_clr also zeroes all store entries in the same edge.

Ports:
- clk_sys  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  request expansion of key_in; sampled every edge.
- key_in  in  128  cipher key, sampled with start.
- key_clr  in  1  abort/invalidate; returns to IDLE.
- busy  out  1  expansion in progress.
- key_ready  out  1  all 11 keys valid in store.
- rk_rd_en  in  1  read request.
- rk_idx  in  4  read index 0..10.
- rk_dout  out  128  round key data, registered.
- rk_valid  out  1  rk_dout valid this cycle (1-cycle pulse).
- rk_err  out  1  1-cycle pulse: read with idx>10 or while not key_ready.
- exp_cipher_key  out  128  to expansion cipher_key (latched key).
- exp_round_num  out  4  to expansion round_num.
- exp_rkey_en  out  1  to expansion rkey_en.
- exp_cipher_en  out  1  to expansion cipher_en; constant 0.
- exp_round_key  in  128  from expansion round_key_out (registered in the expansion).

Behaviour:
- Reset values (async, on rst=1): state=IDLE, cnt=0, busy=0, key_ready=0, rk_valid=0, rk_err=0, rk_dout=0, exp_round_num=0, exp_rkey_en=0, exp_cipher_key=0. Store contents are not reset.
- States: IDLE, EXPAND, READY.
- IDLE, start=1 at edge E0: latch key_in into exp_cipher_key and slot 0, cnt<=0, go EXPAND.
- EXPAND, cycle with cnt=c:
  - exp_round_num=c.
  - exp_rkey_en = (c<=9).
  - If c>=1, write exp_round_key into slot c at the closing edge. The expansion's rk[c] became visible one edge after round_num=c-1 was driven.
  - cnt<=c+1.
  - At c=10: write slot 10, go READY.
- Timing: key_ready rises after edge E0+11; busy=1 exactly for the 11 EXPAND cycles.
- exp_round_num and exp_rkey_en are combinational from cnt/state. exp_round_num=0 outside EXPAND.
- READY, start=1: re-expand with the new key (behaves as from IDLE). key_ready drops at the same edge. A read in that cycle is dropped: no rk_valid, no rk_err.
- start in EXPAND: ignored, with no effect on sequence or latched key.
- key_clr (any state): go IDLE, cnt<=0, key_ready<=0.
  - If ZEROIZE_ON_CLR, all slots and exp_cipher_key <=0.
  - key_clr has priority over start in the same cycle.
- Reads:
  - rk_rd_en=1 in READY with rk_idx<=10: rk_dout<=slot[rk_idx], rk_valid=1 next cycle.
  - Otherwise (rk_idx>10 or state!=READY): rk_err=1 next cycle, rk_dout holds its previous value, rk_valid=0.
  - Back-to-back reads are supported at one per cycle.
- rst mid-EXPAND: abort immediately to IDLE; a subsequent start performs a full expansion.

Decomposition:
- aes128_pkg:
  - state enum ks_state_e {IDLE, EXPAND, READY}.
  - constants AES128_NUM_RKEYS=11, AES128_RKEY_W=128, AES128_LAST_RND=4'd10.
- Sub-module aes128_rkey_store: 11x128 register file; one write port (we, waddr, wdata), one registered read port, and a synchronous clear-all input.
- FSM and counter live in aes128_key_sched_ctrl.

Test Plan:
1. Reset, then start with key_in=2b7e151628aed2a6abf7158809cf4f3c, expansion instantiated alongside:
   - busy=1 for 11 cycles, key_ready=1 at cycle 12.
   - Read idx 0 -> 2b7e151628aed2a6abf7158809cf4f3c; idx 1 -> a0fafe1788542cb123a339392a6c7605; idx 10 -> d014f9a8c9ee2589e13f0cc8b6630ca6.
2. Read idx 10 down to 0 on back-to-back cycles -> 11 consecutive rk_valid pulses with the FIPS-197 A.1 keys in reverse order.
3. Read idx 11 and idx 15 in READY -> rk_err pulses, rk_valid=0, rk_dout unchanged. Read idx 3 during EXPAND -> rk_err pulse.
4. start asserted again at EXPAND cycle 5 with key 000102030405060708090a0b0c0d0e0f -> ignored; final slot 10 still d014f9a8c9ee2589e13f0cc8b6630ca6.
5. In READY, start with key 000102030405060708090a0b0c0d0e0f plus simultaneous read -> read dropped, key_ready low for 11 cycles; then idx 10 -> 13111d7fe3944a17f307a78b4d2b30c5.
6. key_clr in READY (ZEROIZE_ON_CLR=1) -> key_ready=0; subsequent read gives rk_err. rst asserted mid-EXPAND -> busy=0 immediately; a new start completes in 11 cycles.

Source files
------------

// File: rtl/aes128_pkg.sv
// Shared types and constants for the AES-128 key schedule controller and its round-key store.
package aes128_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    EXPAND = 2'd1,
    READY  = 2'd2
  } ks_state_e;

  localparam int          AES128_NUM_RKEYS = 11;
  localparam int          AES128_RKEY_W    = 128;
  localparam logic [3:0]  AES128_LAST_RND  = 4'd10;

  function automatic logic rkey_idx_ok(input logic [3:0] idx);
    return (idx <= AES128_LAST_RND);
  endfunction

endpackage

// File: rtl/aes128_rkey_store.sv
// Round-key register file: one write port, one registered read port, synchronous clear-all.
module aes128_rkey_store
  import aes128_pkg::*;
#(
  parameter int DEPTH = AES128_NUM_RKEYS,
  parameter int W     = AES128_RKEY_W
) (
  input  logic         clk_sys,
  input  logic         rst,
  input  logic         clr_all,
  input  logic         we,
  input  logic [3:0]   waddr,
  input  logic [W-1:0] wdata,
  input  logic         rd_en,
  input  logic [3:0]   raddr,
  output logic [W-1:0] rdata
);

  logic [W-1:0] mem_r [DEPTH];

  // Key storage: deliberately not reset; zeroization is the only way to wipe it.
  always_ff @(posedge clk_sys) begin
    if (clr_all) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= {W{1'b0}};
      end
    end else if (we) begin
      mem_r[waddr] <= wdata;
    end
  end

  // Read register holds its value unless a valid read is issued.
  always_ff @(posedge clk_sys or posedge rst) begin
    if (rst) begin
      rdata <= {W{1'b0}};
    end else if (rd_en) begin
      rdata <= mem_r[raddr];
    end
  end

endmodule

// File: rtl/aes128_key_sched_ctrl.sv
// Sequences the shared AES-128 key expansion through rounds 0..9, captures all 11 keys
// and serves them by index to the encrypt and decrypt cores.
module aes128_key_sched_ctrl
  import aes128_pkg::*;
#(
  parameter int NUM_RKEYS      = AES128_NUM_RKEYS,
  parameter bit ZEROIZE_ON_CLR = 1'b1
) (
  input  logic         clk_sys,
  input  logic         rst,
  input  logic         start,
  input  logic [127:0] key_in,
  input  logic         key_clr,
  output logic         busy,
  output logic         key_ready,
  input  logic         rk_rd_en,
  input  logic [3:0]   rk_idx,
  output logic [127:0] rk_dout,
  output logic         rk_valid,
  output logic         rk_err,
  output logic [127:0] exp_cipher_key,
  output logic [3:0]   exp_round_num,
  output logic         exp_rkey_en,
  output logic         exp_cipher_en,
  input  logic [127:0] exp_round_key
);

  ks_state_e      state_r;
  logic [3:0]     cnt_r;
  logic           start_acc_s;
  logic           we_s;
  logic [3:0]     waddr_s;
  logic [127:0]   wdata_s;
  logic           rd_en_s;
  logic           clr_s;

  // Store port control and expansion drive, decoded from state and counter.
  always_comb begin
    start_acc_s   = 1'b0;
    we_s          = 1'b0;
    waddr_s       = 4'd0;
    wdata_s       = key_in;
    rd_en_s       = 1'b0;
    clr_s         = 1'b0;
    exp_round_num = 4'd0;
    exp_rkey_en   = 1'b0;
    if (key_clr) begin
      clr_s = ZEROIZE_ON_CLR;
    end else if (state_r == EXPAND) begin
      exp_round_num = cnt_r;
      exp_rkey_en   = (cnt_r <= 4'd9);
      // rk[c] is already registered in the expansion when the counter reads c.
      if (cnt_r != 4'd0) begin
        we_s    = 1'b1;
        waddr_s = cnt_r;
        wdata_s = exp_round_key;
      end else begin
        we_s    = 1'b0;
      end
    end else begin
      start_acc_s = start;
      we_s        = start;
      rd_en_s     = rk_rd_en && !start && (state_r == READY) && rkey_idx_ok(rk_idx);
    end
  end

  assign exp_cipher_en = 1'b0;

  // Sequencer FSM with registered status and read-response flags.
  always_ff @(posedge clk_sys or posedge rst) begin
    if (rst) begin
      state_r        <= IDLE;
      cnt_r          <= 4'd0;
      busy           <= 1'b0;
      key_ready      <= 1'b0;
      rk_valid       <= 1'b0;
      rk_err         <= 1'b0;
      exp_cipher_key <= 128'd0;
    end else begin
      rk_valid <= 1'b0;
      rk_err   <= 1'b0;
      if (key_clr) begin
        state_r   <= IDLE;
        cnt_r     <= 4'd0;
        busy      <= 1'b0;
        key_ready <= 1'b0;
        rk_err    <= rk_rd_en;
        if (ZEROIZE_ON_CLR) begin
          exp_cipher_key <= 128'd0;
        end
      end else begin
        case (state_r)
          IDLE: begin
            rk_err <= rk_rd_en;
            if (start_acc_s) begin
              exp_cipher_key <= key_in;
              cnt_r          <= 4'd0;
              busy           <= 1'b1;
              state_r        <= EXPAND;
            end
          end
          EXPAND: begin
            rk_err <= rk_rd_en;
            if (cnt_r == AES128_LAST_RND) begin
              cnt_r     <= 4'd0;
              busy      <= 1'b0;
              key_ready <= 1'b1;
              state_r   <= READY;
            end else begin
              cnt_r <= cnt_r + 4'd1;
            end
          end
          READY: begin
            // A re-key request swallows any read issued in the same cycle.
            if (start_acc_s) begin
              exp_cipher_key <= key_in;
              cnt_r          <= 4'd0;
              busy           <= 1'b1;
              key_ready      <= 1'b0;
              state_r        <= EXPAND;
            end else if (rk_rd_en) begin
              rk_valid <= rd_en_s;
              rk_err   <= !rd_en_s;
            end
          end
          default: begin
            state_r   <= IDLE;
            cnt_r     <= 4'd0;
            busy      <= 1'b0;
            key_ready <= 1'b0;
          end
        endcase
      end
    end
  end

  aes128_rkey_store #(
    .DEPTH (NUM_RKEYS),
    .W     (AES128_RKEY_W)
  ) u_store (
    .clk_sys (clk_sys),
    .rst     (rst),
    .clr_all (clr_s),
    .we      (we_s),
    .waddr   (waddr_s),
    .wdata   (wdata_s),
    .rd_en   (rd_en_s),
    .raddr   (rk_idx),
    .rdata   (rk_dout)
  );

endmodule

// File: tb/tb_aes128_key_sched_ctrl.sv
// Directed bench for aes128_key_sched_ctrl with a table-driven stand-in for the key expansion.
module tb_aes128_key_sched_ctrl;

  logic         clk_sys = 1'b0;
  logic         rst;
  logic         start;
  logic [127:0] key_in;
  logic         key_clr;
  logic         busy;
  logic         key_ready;
  logic         rk_rd_en;
  logic [3:0]   rk_idx;
  logic [127:0] rk_dout;
  logic         rk_valid;
  logic         rk_err;
  logic [127:0] exp_cipher_key;
  logic [3:0]   exp_round_num;
  logic         exp_rkey_en;
  logic         exp_cipher_en;
  logic [127:0] exp_round_key = 128'd0;

  int checks = 0;
  int errors = 0;

  localparam logic [127:0] KEY_A = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] KEY_B = 128'h000102030405060708090a0b0c0d0e0f;

  logic [127:0] tbl_a [0:10];
  logic [127:0] tbl_b [0:10];

  always #5 clk_sys = ~clk_sys;

  aes128_key_sched_ctrl dut (
    .clk_sys        (clk_sys),
    .rst            (rst),
    .start          (start),
    .key_in         (key_in),
    .key_clr        (key_clr),
    .busy           (busy),
    .key_ready      (key_ready),
    .rk_rd_en       (rk_rd_en),
    .rk_idx         (rk_idx),
    .rk_dout        (rk_dout),
    .rk_valid       (rk_valid),
    .rk_err         (rk_err),
    .exp_cipher_key (exp_cipher_key),
    .exp_round_num  (exp_round_num),
    .exp_rkey_en    (exp_rkey_en),
    .exp_cipher_en  (exp_cipher_en),
    .exp_round_key  (exp_round_key)
  );

  // Expansion stand-in: registered rk[round_num+1] for whichever key is latched.
  always @(posedge clk_sys) begin
    if (exp_rkey_en && exp_round_num <= 4'd9) begin
      if (exp_cipher_key == KEY_B) exp_round_key <= tbl_b[exp_round_num + 4'd1];
      else                         exp_round_key <= tbl_a[exp_round_num + 4'd1];
    end
  end

  task automatic tick();
    @(posedge clk_sys);
    #1;
  endtask

  task automatic do_start(input logic [127:0] k);
    key_in = k;
    start  = 1'b1;
    tick();
    start  = 1'b0;
  endtask

  task automatic wait_ready(output int cyc);
    cyc = 0;
    while (busy && cyc < 30) begin
      cyc++;
      tick();
    end
  endtask

  task automatic do_read(input logic [3:0] idx, output logic v, output logic e, output logic [127:0] d);
    rk_idx   = idx;
    rk_rd_en = 1'b1;
    tick();
    rk_rd_en = 1'b0;
    v = rk_valid;
    e = rk_err;
    d = rk_dout;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    checks++;
    if ({busy, key_ready, rk_valid, rk_err, exp_rkey_en, exp_cipher_en} !== 6'b000000) begin
      errors++;
      $display("FAIL reset_flags: got %b expected 000000",
               {busy, key_ready, rk_valid, rk_err, exp_rkey_en, exp_cipher_en});
    end
    checks++;
    if (rk_dout !== 128'd0 || exp_cipher_key !== 128'd0 || exp_round_num !== 4'd0) begin
      errors++;
      $display("FAIL reset_data: got dout=%h key=%h rn=%0d expected zeros", rk_dout, exp_cipher_key, exp_round_num);
    end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_expand();
    logic v, e;
    logic [127:0] d;
    do_start(KEY_A);
    for (int i = 0; i <= 10; i++) begin
      checks++;
      if (busy !== 1'b1 || key_ready !== 1'b0 || exp_round_num !== 4'(i) || exp_rkey_en !== (i <= 9)) begin
        errors++;
        $display("FAIL expand_cycle%0d: got busy=%b rdy=%b rn=%0d en=%b expected busy=1 rdy=0 rn=%0d en=%b",
                 i, busy, key_ready, exp_round_num, exp_rkey_en, i, (i <= 9));
      end
      tick();
    end
    checks++;
    if (busy !== 1'b0 || key_ready !== 1'b1 || exp_round_num !== 4'd0) begin
      errors++;
      $display("FAIL expand_done: got busy=%b rdy=%b rn=%0d expected busy=0 rdy=1 rn=0", busy, key_ready, exp_round_num);
    end
    checks++;
    if (exp_cipher_key !== KEY_A) begin
      errors++;
      $display("FAIL latched_key: got %h expected %h", exp_cipher_key, KEY_A);
    end
    do_read(4'd0, v, e, d);
    checks++;
    if (v !== 1'b1 || e !== 1'b0 || d !== 128'h2b7e151628aed2a6abf7158809cf4f3c) begin
      errors++;
      $display("FAIL read_idx0: got v=%b e=%b %h expected v=1 e=0 2b7e151628aed2a6abf7158809cf4f3c", v, e, d);
    end
    do_read(4'd1, v, e, d);
    checks++;
    if (v !== 1'b1 || d !== 128'ha0fafe1788542cb123a339392a6c7605) begin
      errors++;
      $display("FAIL read_idx1: got v=%b %h expected v=1 a0fafe1788542cb123a339392a6c7605", v, d);
    end
    do_read(4'd10, v, e, d);
    checks++;
    if (v !== 1'b1 || d !== 128'hd014f9a8c9ee2589e13f0cc8b6630ca6) begin
      errors++;
      $display("FAIL read_idx10: got v=%b %h expected v=1 d014f9a8c9ee2589e13f0cc8b6630ca6", v, d);
    end
    tick();
    checks++;
    if (rk_valid !== 1'b0) begin
      errors++;
      $display("FAIL valid_pulse: got %b expected 0", rk_valid);
    end
  endtask

  task automatic test_back_to_back();
    rk_rd_en = 1'b1;
    for (int i = 10; i >= 0; i--) begin
      rk_idx = 4'(i);
      tick();
      checks++;
      if (rk_valid !== 1'b1 || rk_err !== 1'b0 || rk_dout !== tbl_a[i]) begin
        errors++;
        $display("FAIL b2b_idx%0d: got v=%b e=%b %h expected v=1 e=0 %h", i, rk_valid, rk_err, rk_dout, tbl_a[i]);
      end
    end
    rk_rd_en = 1'b0;
    tick();
    checks++;
    if (rk_valid !== 1'b0) begin
      errors++;
      $display("FAIL b2b_end: got v=%b expected 0", rk_valid);
    end
  endtask

  task automatic test_bad_reads();
    logic v, e;
    logic [127:0] d;
    do_read(4'd4, v, e, d);
    do_read(4'd11, v, e, d);
    checks++;
    if (v !== 1'b0 || e !== 1'b1 || d !== tbl_a[4]) begin
      errors++;
      $display("FAIL read_idx11: got v=%b e=%b %h expected v=0 e=1 %h", v, e, d, tbl_a[4]);
    end
    do_read(4'd15, v, e, d);
    checks++;
    if (v !== 1'b0 || e !== 1'b1 || d !== tbl_a[4]) begin
      errors++;
      $display("FAIL read_idx15: got v=%b e=%b %h expected v=0 e=1 %h", v, e, d, tbl_a[4]);
    end
    tick();
    checks++;
    if (rk_err !== 1'b0) begin
      errors++;
      $display("FAIL err_pulse: got %b expected 0", rk_err);
    end
  endtask

  task automatic test_start_ignored();
    logic v, e;
    logic [127:0] d;
    int cyc;
    do_start(KEY_A);
    for (int i = 0; i <= 10; i++) begin
      rk_rd_en = (i == 3);
      rk_idx   = 4'd3;
      start    = (i == 5);
      key_in   = KEY_B;
      tick();
      if (i == 3) begin
        checks++;
        if (rk_err !== 1'b1 || rk_valid !== 1'b0) begin
          errors++;
          $display("FAIL read_in_expand: got e=%b v=%b expected e=1 v=0", rk_err, rk_valid);
        end
      end
    end
    rk_rd_en = 1'b0;
    start    = 1'b0;
    wait_ready(cyc);
    checks++;
    if (key_ready !== 1'b1 || exp_cipher_key !== KEY_A) begin
      errors++;
      $display("FAIL start_ignored: got rdy=%b key=%h expected rdy=1 %h", key_ready, exp_cipher_key, KEY_A);
    end
    do_read(4'd10, v, e, d);
    checks++;
    if (v !== 1'b1 || d !== 128'hd014f9a8c9ee2589e13f0cc8b6630ca6) begin
      errors++;
      $display("FAIL ignored_slot10: got v=%b %h expected v=1 d014f9a8c9ee2589e13f0cc8b6630ca6", v, d);
    end
  endtask

  task automatic test_rekey();
    logic v, e;
    logic [127:0] d;
    int low;
    key_in   = KEY_B;
    start    = 1'b1;
    rk_rd_en = 1'b1;
    rk_idx   = 4'd2;
    tick();
    start    = 1'b0;
    rk_rd_en = 1'b0;
    checks++;
    if (rk_valid !== 1'b0 || rk_err !== 1'b0 || key_ready !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL rekey_drop: got v=%b e=%b rdy=%b busy=%b expected 0 0 0 1", rk_valid, rk_err, key_ready, busy);
    end
    low = 0;
    while (!key_ready && low < 30) begin
      low++;
      tick();
    end
    checks++;
    if (low !== 11) begin
      errors++;
      $display("FAIL rekey_low_cycles: got %0d expected 11", low);
    end
    do_read(4'd10, v, e, d);
    checks++;
    if (v !== 1'b1 || d !== 128'h13111d7fe3944a17f307a78b4d2b30c5) begin
      errors++;
      $display("FAIL rekey_idx10: got v=%b %h expected v=1 13111d7fe3944a17f307a78b4d2b30c5", v, d);
    end
    do_read(4'd0, v, e, d);
    checks++;
    if (v !== 1'b1 || d !== KEY_B) begin
      errors++;
      $display("FAIL rekey_idx0: got v=%b %h expected v=1 %h", v, d, KEY_B);
    end
  endtask

  task automatic test_clear_and_abort();
    logic v, e;
    logic [127:0] d;
    int cyc;
    key_clr = 1'b1;
    tick();
    key_clr = 1'b0;
    checks++;
    if (key_ready !== 1'b0 || busy !== 1'b0 || exp_cipher_key !== 128'd0) begin
      errors++;
      $display("FAIL key_clr: got rdy=%b busy=%b key=%h expected rdy=0 busy=0 key=0", key_ready, busy, exp_cipher_key);
    end
    do_read(4'd0, v, e, d);
    checks++;
    if (v !== 1'b0 || e !== 1'b1) begin
      errors++;
      $display("FAIL read_after_clr: got v=%b e=%b expected v=0 e=1", v, e);
    end
    do_start(KEY_A);
    tick();
    tick();
    tick();
    rst = 1'b1;
    #1;
    checks++;
    if (busy !== 1'b0 || exp_round_num !== 4'd0 || exp_rkey_en !== 1'b0) begin
      errors++;
      $display("FAIL rst_mid_expand: got busy=%b rn=%0d en=%b expected 0 0 0", busy, exp_round_num, exp_rkey_en);
    end
    tick();
    rst = 1'b0;
    tick();
    do_start(KEY_A);
    wait_ready(cyc);
    checks++;
    if (cyc !== 11 || key_ready !== 1'b1) begin
      errors++;
      $display("FAIL restart_cycles: got %0d rdy=%b expected 11 rdy=1", cyc, key_ready);
    end
    do_read(4'd5, v, e, d);
    checks++;
    if (v !== 1'b1 || d !== 128'hd4d1c6f87c839d87caf2b8bc11f915bc) begin
      errors++;
      $display("FAIL restart_idx5: got v=%b %h expected v=1 d4d1c6f87c839d87caf2b8bc11f915bc", v, d);
    end
  endtask

  initial begin
    tbl_a[0]  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    tbl_a[1]  = 128'ha0fafe1788542cb123a339392a6c7605;
    tbl_a[2]  = 128'hf2c295f27a96b9435935807a7359f67f;
    tbl_a[3]  = 128'h3d80477d4716fe3e1e237e446d7a883b;
    tbl_a[4]  = 128'hef44a541a8525b7fb671253bdb0bad00;
    tbl_a[5]  = 128'hd4d1c6f87c839d87caf2b8bc11f915bc;
    tbl_a[6]  = 128'h6d88a37a110b3efddbf98641ca0093fd;
    tbl_a[7]  = 128'h4e54f70e5f5fc9f384a64fb24ea6dc4f;
    tbl_a[8]  = 128'head27321b58dbad2312bf5607f8d292f;
    tbl_a[9]  = 128'hac7766f319fadc2128d12941575c006e;
    tbl_a[10] = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
    tbl_b[0]  = 128'h000102030405060708090a0b0c0d0e0f;
    tbl_b[1]  = 128'hd6aa74fdd2af72fadaa678f1d6ab76fe;
    tbl_b[2]  = 128'hb692cf0b643dbdf1be9bc5006830b3fe;
    tbl_b[3]  = 128'hb6ff744ed2c2c9bf6c590cbf0469bf41;
    tbl_b[4]  = 128'h47f7f7bc95353e03f96c32bcfd058dfd;
    tbl_b[5]  = 128'h3caaa3e8a99f9deb50f3af57adf622aa;
    tbl_b[6]  = 128'h5e390f7df7a69296a7553dc10aa31f6b;
    tbl_b[7]  = 128'h14f9701ae35fe28c440adf4d4ea9c026;
    tbl_b[8]  = 128'h47438735a41c65b9e016baf4aebf7ad2;
    tbl_b[9]  = 128'h549932d1f08557681093ed9cbe2c974e;
    tbl_b[10] = 128'h13111d7fe3944a17f307a78b4d2b30c5;
    rst      = 1'b1;
    start    = 1'b0;
    key_in   = 128'd0;
    key_clr  = 1'b0;
    rk_rd_en = 1'b0;
    rk_idx   = 4'd0;
    test_reset();
    test_expand();
    test_back_to_back();
    test_bad_reads();
    test_start_ignored();
    test_rekey();
    test_clear_and_abort();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
